comb_delay_sequencer: RTL and testbench
=======================================

Name: comb_delay_sequencer

Overview:
Frame-level controller for the comb/echo datapath. It detects each audio frame boundary from AUD_DACLRCK, captures the packed stereo sample, and drives a single-port synchronous delay-line RAM as a circular buffer (write x(n), read x(n-D)). It then presents the aligned pair x(n) / x(n-D) with a one-cycle valid strobe to the downstream subtractor. This replaces fixed shift-register delay taps with a run-time-configurable delay D.

Parameters:
ADDR_W, 10, delay-line address width; buffer depth 2^ADDR_W frames; max delay 2^ADDR_W-1.
SYNC_STAGES, 2, synchroniser flops on AUD_DACLRCK (minimum 2).

Ports:
clk  in  1  system clock; all logic is on its rising edge.
rst  in  1  asynchronous, active-low reset.
AUD_DACLRCK  in  1  DAC left/right clock, asynchronous to clk.
audioIn  in  32  packed sample, left [31:16], right [15:0].
delay_cfg  in  ADDR_W  requested delay D in frames.
ovr_clr  in  1  clears the overrun flag.
ram_addr  out  ADDR_W  delay RAM address.
ram_we  out  1  delay RAM write enable.
ram_wdata  out  32  delay RAM write data.
ram_rdata  in  32  delay RAM read data; valid the cycle after the address is presented.
cur_sample  out  32  x(n), held until the next DONE.
delayed_sample  out  32  x(n-D), held until the next DONE.
out_valid  out  1  one-cycle strobe; both samples are updated.
busy  out  1  high whenever state != IDLE.
overrun  out  1  sticky; set when a frame tick was dropped.

Behaviour:
- Reset (async, rst=0): state IDLE; wr_ptr=0; fill_cnt=0; delay_act=1; sync flops=0.
- All outputs are 0 during reset.
- Frame tick: AUD_DACLRCK passes through SYNC_STAGES flops. frame_tick is a 1-cycle pulse on a rising edge of the synchronised signal.
- FSM (one state per cycle):
  - IDLE -> CAPTURE on frame_tick.
  - CAPTURE: sample_reg<=audioIn; delay_act<=(delay_cfg==0)?1:delay_cfg.
  - WRITE: ram_addr=wr_ptr, ram_we=1, ram_wdata=sample_reg.
  - READ: ram_addr=(wr_ptr-delay_act) mod 2^ADDR_W, ram_we=0.
  - WAIT: rd_reg<=(fill_cnt>=delay_act)?ram_rdata:0.
  - DONE: cur_sample<=sample_reg; delayed_sample<=rd_reg; out_valid=1; wr_ptr<=wr_ptr+1 (wraps); fill_cnt<=min(fill_cnt+1, 2^ADDR_W-1); -> IDLE.
- Latency: if frame_tick is high in cycle T, out_valid is high in cycle T+5. Throughput is one frame per 6 cycles minimum.
- ram_we is high only in WRITE. ram_addr is 0 in IDLE/CAPTURE/WAIT/DONE.
- Delay changes take effect at the next CAPTURE only. No partial frame uses a mixed delay.
- Increasing D beyond fill_cnt yields delayed_sample=0 until enough history exists.
- Overrun: frame_tick while state != IDLE sets overrun=1; that tick is dropped and the FSM is unaffected.
- ovr_clr=1 clears overrun. If ovr_clr and a new overrun tick occur in the same cycle, set wins.
- Reset mid-frame: the FSM aborts and all state clears, including fill_cnt. History is discarded and the first ≥D frames after reset output zero delay.
- Widths: pointer arithmetic is ADDR_W-bit modular. Samples are passed through unmodified; there is no arithmetic on audio data.

Decomposition:
- Shared package (audio_pkg): state enum {IDLE,CAPTURE,WRITE,READ,WAIT,DONE}, default ADDR_W, packed-sample field positions (L=[31:16], R=[15:0]).
- One sub-module: lrck_edge_sync (SYNC_STAGES flops plus rising-edge detect, async active-low reset), reusable for AUD_ADCLRCK.

Test Plan:
1. Reset, then idle with no LRCK edge -> all outputs 0, busy=0. Assert rst=0 mid-WRITE -> ram_we drops to 0 immediately, state IDLE.
2. delay_cfg=4; frames carry audioIn=0x00010001*k for k=1..8 -> delayed_sample=0 for k=1..4; k=5 yields 0x00010001; k=8 yields 0x00040004. out_valid arrives 5 cycles after each tick.
3. ADDR_W=4, delay_cfg=15, 40 frames with audioIn=k -> wr_ptr wraps 15->0. Frame k>15 outputs k-15; frame 20 reads ram_addr=(19-15)=4.
4. delay_cfg=0 -> behaves as D=1. Frame k outputs k-1; frame 1 outputs 0.
5. Switch delay_cfg 2->6 at frame 10 -> frames ≤10 use D=2. Frames 11.. use D=6 with valid history (fill_cnt=10), so frame 11 outputs 5. Change delay_cfg while busy -> no effect until the next CAPTURE.
6. Two LRCK rising edges 3 clk apart -> the second tick is dropped, overrun=1, exactly one out_valid. Pulse ovr_clr -> overrun=0. Assert ovr_clr coincident with a new overrun tick -> overrun stays 1.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types for the comb/echo frame sequencer: FSM states, stereo sample layout, default sizes.
package audio_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned SAMPLE_W   = 32;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WRITE,
    READ,
    WAIT,
    DONE
  } seq_state_e;

  // Packed stereo sample: left in [31:16], right in [15:0]
  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
  } stereo_t;

endpackage

// File: rtl/comb_delay_sequencer_if.sv
// Delay-line RAM port plus the aligned x(n)/x(n-D) output bus of the comb sequencer.
interface comb_delay_sequencer_if
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  stereo_t           ram_wdata;
  stereo_t           ram_rdata;
  stereo_t           cur_sample;
  stereo_t           delayed_sample;
  logic              out_valid;

  modport master (
    output ram_addr,
    output ram_we,
    output ram_wdata,
    output cur_sample,
    output delayed_sample,
    output out_valid,
    input  ram_rdata
  );

  modport slave (
    input  ram_addr,
    input  ram_we,
    input  ram_wdata,
    input  cur_sample,
    input  delayed_sample,
    input  out_valid,
    output ram_rdata
  );

endinterface

// File: rtl/lrck_edge_sync.sv
// Synchronises an asynchronous LRCK into clk and flags its rising edges with a one-cycle pulse.
module lrck_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lrck_i,
  output logic tick_c_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], lrck_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_c_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/comb_delay_sequencer.sv
// Frame controller: on each LRCK frame writes x(n) into a circular delay RAM and reads back x(n-D).
module comb_delay_sequencer
  import audio_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                AUD_DACLRCK,
  input  logic [SAMPLE_W-1:0] audioIn,
  input  logic [ADDR_W-1:0]   delay_cfg,
  input  logic                ovr_clr,
  comb_delay_sequencer_if.master bus,
  output logic                busy,
  output logic                overrun
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] FILL_MAX = '1;

  logic frame_tick;

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] fill_q, fill_d;
  logic [ADDR_W-1:0] delay_q, delay_d;
  stereo_t           sample_q, sample_d;
  stereo_t           cur_q, cur_d;
  stereo_t           del_q, del_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              ovr_q, ovr_d;

  lrck_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_lrck_sync (
    .clk      (clk),
    .rst_n    (rst),
    .lrck_i   (AUD_DACLRCK),
    .tick_c_o (frame_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      delay_q  <= PTR_ONE;
      sample_q <= '0;
      cur_q    <= '0;
      del_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      delay_q  <= delay_d;
      sample_q <= sample_d;
      cur_q    <= cur_d;
      del_q    <= del_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  end

  // RAM controls and the valid strobe are registered one state early so they line up with it
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    delay_d  = delay_q;
    sample_d = sample_q;
    cur_d    = cur_q;
    del_d    = del_q;
    addr_d   = '0;
    we_d     = 1'b0;
    valid_d  = 1'b0;
    ovr_d    = ovr_q;

    case (state_q)
      IDLE: begin
        if (frame_tick) state_d = CAPTURE;
      end
      CAPTURE: begin
        sample_d = stereo_t'(audioIn);
        delay_d  = (delay_cfg == '0) ? PTR_ONE : delay_cfg;
        addr_d   = wr_ptr_q;
        we_d     = 1'b1;
        state_d  = WRITE;
      end
      WRITE: begin
        addr_d  = wr_ptr_q - delay_q;
        state_d = READ;
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Without enough history the delayed tap reads as silence
        cur_d   = sample_q;
        del_d   = (fill_q >= delay_q) ? bus.ram_rdata : '0;
        valid_d = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + PTR_ONE;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    if (frame_tick && (state_q != IDLE)) begin
      ovr_d = 1'b1;
    end else if (ovr_clr) begin
      ovr_d = 1'b0;
    end
  end

  assign bus.ram_addr       = addr_q;
  assign bus.ram_we         = we_q;
  assign bus.ram_wdata      = sample_q;
  assign bus.cur_sample     = cur_q;
  assign bus.delayed_sample = del_q;
  assign bus.out_valid      = valid_q;
  assign busy               = busy_q;
  assign overrun            = ovr_q;

endmodule

// File: tb/tb_comb_delay_sequencer.sv
// Directed bench for comb_delay_sequencer with a 16-entry synchronous delay RAM model.
module tb_comb_delay_sequencer;
  import audio_pkg::*;

  localparam int unsigned AW = 4;

  typedef struct {
    int          k;
    logic [31:0] audio;
    logic [3:0]  cfg;
    logic [3:0]  cfg_mid;
    logic [3:0]  waddr;
    logic [3:0]  raddr;
    logic [31:0] exp_del;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lrck = 1'b0;
  logic [31:0] audio_in = '0;
  logic [3:0]  delay_cfg = '0;
  logic        ovr_clr = 1'b0;
  logic        busy;
  logic        overrun;
  logic [31:0] mem [16];

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  comb_delay_sequencer_if #(.ADDR_W(AW)) bus ();

  comb_delay_sequencer #(
    .ADDR_W      (AW),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .AUD_DACLRCK (lrck),
    .audioIn     (audio_in),
    .delay_cfg   (delay_cfg),
    .ovr_clr     (ovr_clr),
    .bus         (bus),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int k, input logic [31:0] audio, input logic [3:0] cfg,
                              input logic [3:0] cfg_mid, input logic [31:0] exp_del);
    vec_t v;
    int   deff;
    deff      = (cfg == 4'd0) ? 1 : int'(cfg);
    v.k       = k;
    v.audio   = audio;
    v.cfg     = cfg;
    v.cfg_mid = cfg_mid;
    v.waddr   = 4'(k - 1);
    v.raddr   = 4'(k - 1 - deff);
    v.exp_del = exp_del;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; lrck = 1'b0; ovr_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  // One frame: LRCK rise, then fixed-cycle checks of the RAM handshake and aligned outputs
  task automatic run_frame(input vec_t v);
    @(negedge clk);
    lrck = 1'b1; audio_in = v.audio; delay_cfg = v.cfg;
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #1;
      if (c == 2) check($sformatf("busy k=%0d", v.k), 32'(busy), 32'd1);
      if (c == 3) begin
        check($sformatf("we k=%0d", v.k), 32'(bus.ram_we), 32'd1);
        check($sformatf("waddr k=%0d", v.k), 32'(bus.ram_addr), 32'(v.waddr));
        check($sformatf("wdata k=%0d", v.k), bus.ram_wdata, v.audio);
        delay_cfg = v.cfg_mid;
        audio_in  = ~v.audio;
      end
      if (c == 4) begin
        check($sformatf("rd_we k=%0d", v.k), 32'(bus.ram_we), 32'd0);
        check($sformatf("raddr k=%0d", v.k), 32'(bus.ram_addr), 32'(v.raddr));
      end
      if (c == 5) check($sformatf("valid_early k=%0d", v.k), 32'(bus.out_valid), 32'd0);
      if (c == 6) begin
        check($sformatf("valid k=%0d", v.k), 32'(bus.out_valid), 32'd1);
        check($sformatf("cur k=%0d", v.k), bus.cur_sample, v.audio);
        check($sformatf("delayed k=%0d", v.k), bus.delayed_sample, v.exp_del);
      end
    end
    @(posedge clk); #1;
    check($sformatf("valid_late k=%0d", v.k), 32'(bus.out_valid), 32'd0);
    check($sformatf("idle k=%0d", v.k), 32'(busy), 32'd0);
    @(negedge clk);
    lrck = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic run_list();
    for (int i = 0; i < vecs.size(); i++) run_frame(vecs[i]);
    vecs.delete();
  endtask

  // Two LRCK rises 3 clocks apart; optionally pulse ovr_clr on the dropped tick's cycle
  task automatic double_tick(input bit clr_on_tick);
    int nvalid;
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lrck    = (i == 0) || (i >= 3 && i <= 5);
      ovr_clr = clr_on_tick && (i == 5);
      @(posedge clk); #1;
      if (bus.out_valid) nvalid++;
      if (i == 4) check($sformatf("ovr_before clr=%0d", clr_on_tick), 32'(overrun), 32'd0);
      if (i == 5) check($sformatf("ovr_set clr=%0d", clr_on_tick), 32'(overrun), 32'd1);
    end
    ovr_clr = 1'b0;
    check($sformatf("one_valid clr=%0d", clr_on_tick), 32'(nvalid), 32'd1);
    check($sformatf("ovr_sticky clr=%0d", clr_on_tick), 32'(overrun), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(bus.ram_we), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(bus.out_valid), 32'd0);
    check("idle_addr", 32'(bus.ram_addr), 32'd0);
    check("idle_cur", bus.cur_sample, 32'd0);
    check("idle_del", bus.delayed_sample, 32'd0);

    // delay_cfg = 0 behaves as D = 1
    vecs.push_back(mk(1, 32'h0000_00A1, 4'd0, 4'd0, 32'h0000_0000));
    vecs.push_back(mk(2, 32'h0000_00A2, 4'd0, 4'd0, 32'h0000_00A1));
    vecs.push_back(mk(3, 32'h0000_00A3, 4'd0, 4'd0, 32'h0000_00A2));
    vecs.push_back(mk(4, 32'h0000_00A4, 4'd0, 4'd0, 32'h0000_00A3));
    run_list();

    // Reset while in WRITE: RAM write enable and outputs drop asynchronously
    @(negedge clk);
    lrck = 1'b1; audio_in = 32'h1234_5678; delay_cfg = 4'd1;
    repeat (4) @(posedge clk);
    #1;
    check("midwr_we_before", 32'(bus.ram_we), 32'd1);
    rst = 1'b0;
    #1;
    check("midwr_we", 32'(bus.ram_we), 32'd0);
    check("midwr_busy", 32'(busy), 32'd0);
    check("midwr_addr", 32'(bus.ram_addr), 32'd0);
    check("midwr_cur", bus.cur_sample, 32'd0);
    lrck = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(posedge clk);

    // D = 4 straight after reset: history from before the reset must not leak out
    vecs.push_back(mk(1, 32'h0001_0001, 4'd4, 4'd4, 32'h0000_0000));
    vecs.push_back(mk(2, 32'h0002_0002, 4'd4, 4'd4, 32'h0000_0000));
    vecs.push_back(mk(3, 32'h0003_0003, 4'd4, 4'd4, 32'h0000_0000));
    vecs.push_back(mk(4, 32'h0004_0004, 4'd4, 4'd4, 32'h0000_0000));
    vecs.push_back(mk(5, 32'h0005_0005, 4'd4, 4'd4, 32'h0001_0001));
    vecs.push_back(mk(6, 32'h0006_0006, 4'd4, 4'd4, 32'h0002_0002));
    vecs.push_back(mk(7, 32'h0007_0007, 4'd4, 4'd4, 32'h0003_0003));
    vecs.push_back(mk(8, 32'h0008_0008, 4'd4, 4'd4, 32'h0004_0004));
    run_list();

    // Maximum delay with pointer wrap over 40 frames
    do_reset();
    for (int k = 1; k <= 40; k++)
      vecs.push_back(mk(k, 32'(k), 4'd15, 4'd15, (k > 15) ? 32'(k - 15) : 32'd0));
    run_list();

    // Delay change 2 -> 6; a change while busy (frame 10) waits for the next capture
    do_reset();
    for (int k = 1; k <= 10; k++)
      vecs.push_back(mk(k, 32'(k), 4'd2, (k == 10) ? 4'd6 : 4'd2,
                        (k > 2) ? 32'(k - 2) : 32'd0));
    for (int k = 11; k <= 14; k++)
      vecs.push_back(mk(k, 32'(k), 4'd6, 4'd6, 32'(k - 6)));
    run_list();

    // Overrun: dropped tick, clear, and set-wins-over-clear
    double_tick(1'b0);
    @(negedge clk); ovr_clr = 1'b1;
    @(posedge clk); #1;
    check("ovr_clr", 32'(overrun), 32'd0);
    @(negedge clk); ovr_clr = 1'b0;
    repeat (4) @(posedge clk);
    double_tick(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
